// File: rtl/ohr_tcam_pkg.sv
// Shared definitions for the route-table TCAM writer: command opcodes,
// entry field layout, controller state encoding and the empty-entry value.
package ohr_tcam_pkg;

  localparam int TCAM_WIDTH = 32;
  localparam int TCAM_SIZE  = 32;
  localparam int TCAM_IDX_W = 8;
  localparam int TCAM_IF_W  = 4;

  typedef enum logic [1:0] {
    OP_ADD       = 2'b00,
    OP_DELETE    = 2'b01,
    OP_CLEAR_ALL = 2'b10,
    OP_RSVD      = 2'b11
  } cmd_op_e;

  // Entry layout, LSB first: mask, then net, then egress interface on top.
  localparam int MASK_LSB = 0;
  localparam int MASK_W   = TCAM_WIDTH;
  localparam int NET_LSB  = MASK_LSB + MASK_W;
  localparam int NET_W    = TCAM_WIDTH;
  localparam int IF_LSB   = NET_LSB + NET_W;
  localparam int IF_W     = TCAM_IF_W;
  localparam int ENTRY_W  = IF_LSB + IF_W;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_SWEEP = 3'd3,
    ST_RESP  = 3'd4
  } wr_state_e;

  // A zero mask with zero interface never matches a programmed route.
  localparam logic [ENTRY_W-1:0] EMPTY_ENTRY = '0;

endpackage

// File: rtl/tcam_prefix_mask.sv
// Converts a prefix length into a left-aligned network mask and flags
// lengths longer than the address width.
module tcam_prefix_mask #(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       i_prefix,
  output logic [WIDTH-1:0] o_mask,
  output logic             o_prefix_err
);

  always_comb begin
    o_prefix_err = (int'(i_prefix) > WIDTH);
    o_mask       = '0;
    if (!o_prefix_err) begin
      for (int i = 0; i < WIDTH; i++) begin
        o_mask[WIDTH-1-i] = (i < int'(i_prefix));
      end
    end
  end

endmodule

// File: rtl/tcam_route_writer.sv
// Route-table programming engine: turns add/delete/clear commands into TCAM
// write cycles and keeps an occupancy bitmap and route count in step.
module tcam_route_writer
  import ohr_tcam_pkg::*;
#(
  parameter int WIDTH = TCAM_WIDTH,
  parameter int SIZE  = TCAM_SIZE,
  parameter int IDX_W = TCAM_IDX_W,
  parameter int IF_W  = TCAM_IF_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [IDX_W-1:0]        cmd_index,
  input  logic [WIDTH-1:0]        cmd_net,
  input  logic [5:0]              cmd_prefix,
  input  logic [IF_W-1:0]         cmd_if,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic                    tcam_wr_en,
  output logic [IDX_W-1:0]        tcam_wr_index,
  output logic [2*WIDTH+IF_W-1:0] tcam_wr_data,
  output logic                    busy,
  output logic [IDX_W-1:0]        route_count,
  output logic [SIZE-1:0]         entry_valid,
  output logic [2:0]              dbg_state
);

  // Handshake: a command is taken on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is only ever high in IDLE.

  localparam int              DATA_W = 2 * WIDTH + IF_W;
  localparam logic [IDX_W:0]  SIZE_C = (IDX_W+1)'(SIZE);
  localparam logic [DATA_W-1:0] EMPTY_D = DATA_W'(EMPTY_ENTRY);

  wr_state_e          r_state, w_state;
  logic [IDX_W:0]     r_cnt, w_cnt;
  cmd_op_e            r_op, w_op;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic               r_ready, w_ready;
  logic               r_rsp_valid, w_rsp_valid;
  logic               r_rsp_err, w_rsp_err;
  logic               r_wr_en, w_wr_en;
  logic [IDX_W-1:0]   r_wr_idx, w_wr_idx;
  logic [DATA_W-1:0]  r_wr_data, w_wr_data;
  logic               r_busy, w_busy;
  logic [IDX_W-1:0]   r_count, w_count;
  logic [SIZE-1:0]    r_valid, w_valid;

  logic [WIDTH-1:0]   w_mask;
  logic               w_prefix_err;
  logic               w_idx_oob;
  logic               w_cmd_err;
  logic               w_accept;
  logic [SIZE-1:0]    w_sel;
  cmd_op_e            w_cmd_op;

  tcam_prefix_mask #(.WIDTH(WIDTH)) u_prefix_mask (
    .i_prefix     (cmd_prefix),
    .o_mask       (w_mask),
    .o_prefix_err (w_prefix_err)
  );

  always_comb begin
    w_cmd_op  = cmd_op_e'(cmd_op);
    w_accept  = cmd_valid && r_ready;
    w_idx_oob = ({1'b0, cmd_index} >= SIZE_C);
    w_cmd_err = (w_cmd_op == OP_RSVD) || w_prefix_err ||
                (((w_cmd_op == OP_ADD) || (w_cmd_op == OP_DELETE)) && w_idx_oob) ||
                ((w_cmd_op == OP_ADD) && (cmd_prefix == 6'd0) && (cmd_if == '0));
  end

  // One-hot select of the slot addressed by the captured command.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_sel[i] = (r_idx == IDX_W'(i));
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_op        = r_op;
    w_idx       = r_idx;
    w_ready     = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_wr_idx;
    w_wr_data   = r_wr_data;
    w_busy      = r_busy;
    w_count     = r_count;
    w_valid     = r_valid;

    case (r_state)
      ST_INIT, ST_SWEEP: begin
        if (r_cnt < SIZE_C) begin
          w_wr_en   = 1'b1;
          w_wr_idx  = r_cnt[IDX_W-1:0];
          w_wr_data = EMPTY_D;
          w_cnt     = r_cnt + (IDX_W+1)'(1);
          w_busy    = 1'b1;
        end else begin
          // Last empty write has just been captured by the TCAM.
          w_busy  = 1'b0;
          w_valid = '0;
          w_count = '0;
          if (r_state == ST_INIT) begin
            w_state = ST_IDLE;
            w_ready = 1'b1;
          end else begin
            w_state     = ST_RESP;
            w_rsp_valid = 1'b1;
          end
        end
      end

      ST_IDLE: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_ready = 1'b0;
          w_op    = w_cmd_op;
          w_idx   = cmd_index;
          if (w_cmd_err) begin
            w_state     = ST_RESP;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
          end else begin
            case (w_cmd_op)
              OP_ADD: begin
                w_state   = ST_WRITE;
                w_wr_en   = 1'b1;
                w_wr_idx  = cmd_index;
                w_wr_data = {cmd_if, cmd_net & w_mask, w_mask};
                w_busy    = 1'b1;
              end
              OP_DELETE: begin
                w_state   = ST_WRITE;
                w_wr_en   = 1'b1;
                w_wr_idx  = cmd_index;
                w_wr_data = EMPTY_D;
                w_busy    = 1'b1;
              end
              default: begin
                // Clear-all: slot 0 goes out now, the sweep covers the rest.
                w_state   = ST_SWEEP;
                w_wr_en   = 1'b1;
                w_wr_idx  = '0;
                w_wr_data = EMPTY_D;
                w_cnt     = (IDX_W+1)'(1);
                w_busy    = 1'b1;
              end
            endcase
          end
        end
      end

      ST_WRITE: begin
        w_state     = ST_RESP;
        w_busy      = 1'b0;
        w_rsp_valid = 1'b1;
        if (r_op == OP_ADD) begin
          w_valid = r_valid | w_sel;
          if ((r_valid & w_sel) == '0) w_count = r_count + IDX_W'(1);
        end else begin
          w_valid = r_valid & ~w_sel;
          if ((r_valid & w_sel) != '0) w_count = r_count - IDX_W'(1);
        end
      end

      ST_RESP: begin
        w_state = ST_IDLE;
        w_ready = 1'b1;
      end

      default: begin
        w_state = ST_INIT;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_op        <= OP_ADD;
      r_idx       <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_count     <= '0;
      r_valid     <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_op        <= w_op;
      r_idx       <= w_idx;
      r_ready     <= w_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_wr_en     <= w_wr_en;
      r_wr_idx    <= w_wr_idx;
      r_wr_data   <= w_wr_data;
      r_busy      <= w_busy;
      r_count     <= w_count;
      r_valid     <= w_valid;
    end
  end

  assign cmd_ready     = r_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_err       = r_rsp_err;
  assign tcam_wr_en    = r_wr_en;
  assign tcam_wr_index = r_wr_idx;
  assign tcam_wr_data  = r_wr_data;
  assign busy          = r_busy;
  assign route_count   = r_count;
  assign entry_valid   = r_valid;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_tcam_route_writer.sv
// Bench for tcam_route_writer: directed scenarios plus randomized commands,
// checked against a slot-occupancy model and an expected-write queue.
module tb_tcam_route_writer;

  localparam int W   = 32;
  localparam int SZ  = 32;
  localparam int IW  = 8;
  localparam int FW  = 4;
  localparam int DW  = 2 * W + FW;
  localparam int EW  = IW + DW;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [IW-1:0] cmd_index;
  logic [W-1:0]  cmd_net;
  logic [5:0]    cmd_prefix;
  logic [FW-1:0] cmd_if;
  logic          rsp_valid;
  logic          rsp_err;
  logic          tcam_wr_en;
  logic [IW-1:0] tcam_wr_index;
  logic [DW-1:0] tcam_wr_data;
  logic          busy;
  logic [IW-1:0] route_count;
  logic [SZ-1:0] entry_valid;
  logic [2:0]    dbg_state;

  tcam_route_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_index     (cmd_index),
    .cmd_net       (cmd_net),
    .cmd_prefix    (cmd_prefix),
    .cmd_if        (cmd_if),
    .rsp_valid     (rsp_valid),
    .rsp_err       (rsp_err),
    .tcam_wr_en    (tcam_wr_en),
    .tcam_wr_index (tcam_wr_index),
    .tcam_wr_data  (tcam_wr_data),
    .busy          (busy),
    .route_count   (route_count),
    .entry_valid   (entry_valid),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int n_checks;
  int n_errors;
  logic [EW-1:0] exp_q[$];
  bit mdl_valid[SZ];
  int mdl_count;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mask(input int p);
    logic [63:0] t;
    t = 64'hFFFF_FFFF << (32 - p);
    return t[31:0];
  endfunction

  function automatic logic [SZ-1:0] mdl_bitmap();
    logic [SZ-1:0] b;
    for (int i = 0; i < SZ; i++) b[i] = mdl_valid[i];
    return b;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < SZ; i++) mdl_valid[i] = 1'b0;
    mdl_count = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_wr_en"}, tcam_wr_en, 0);
    chk({tag, "_wr_index"}, tcam_wr_index, 0);
    chk({tag, "_wr_data"}, tcam_wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_route_count"}, route_count, 0);
    chk({tag, "_entry_valid"}, entry_valid, 0);
  endtask

  // Called at the negedge on which rst_n was released.
  task automatic run_init();
    int t_ready;
    logic [EW-1:0] e;
    exp_q.delete();
    for (int i = 0; i < SZ; i++) exp_q.push_back({8'(i), {DW{1'b0}}});
    t_ready = 0;
    for (int t = 1; t <= 100 && t_ready == 0; t++) begin
      @(negedge clk);
      if (rsp_valid) chk("init_rsp", 1, 0);
      if (tcam_wr_en) begin
        if (exp_q.size() == 0) chk("init_extra_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("init_write", {tcam_wr_index, tcam_wr_data}, e);
        end
        chk("init_busy", busy, 1);
      end
      if (cmd_ready) t_ready = t;
    end
    chk("init_ready_t", t_ready, SZ + 1);
    chk("init_missing", exp_q.size(), 0);
    exp_q.delete();
    mdl_clear();
  endtask

  // driver: issue one command and follow it to its response
  task automatic send_cmd(input logic [1:0] op, input int idx, input logic [W-1:0] net,
                          input int pfx, input logic [FW-1:0] ifc);
    bit err;
    int exp_t, got_t, first_w, guard;
    logic [W-1:0] m;
    logic [EW-1:0] e;
    err = (op == 2'b11) || (pfx > W) || ((op <= 2'b01) && (idx >= SZ)) ||
          ((op == 2'b00) && (pfx == 0) && (ifc == '0));
    exp_q.delete();
    if (err) exp_t = 1;
    else if (op == 2'b10) begin
      for (int i = 0; i < SZ; i++) exp_q.push_back({8'(i), {DW{1'b0}}});
      exp_t = SZ + 1;
    end else begin
      m = ref_mask(pfx);
      if (op == 2'b00) exp_q.push_back({8'(idx), ifc, net & m, m});
      else exp_q.push_back({8'(idx), {DW{1'b0}}});
      exp_t = 2;
    end

    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_index  = 8'(idx);
    cmd_net    = net;
    cmd_prefix = 6'(pfx);
    cmd_if     = ifc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    got_t = 0;
    first_w = 0;
    for (int t = 1; t <= 60 && got_t == 0; t++) begin
      @(negedge clk);
      if (tcam_wr_en) begin
        if (first_w == 0) first_w = t;
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("write", {tcam_wr_index, tcam_wr_data}, e);
        end
        if (op == 2'b10) begin
          chk("sweep_busy", busy, 1);
          chk("sweep_ready", cmd_ready, 0);
        end
      end
      if (rsp_valid) begin
        got_t = t;
        chk("rsp_err", rsp_err, err);
        chk("ready_in_resp", cmd_ready, 0);
      end
    end
    chk("rsp_latency", got_t, exp_t);
    chk("missing_writes", exp_q.size(), 0);
    if (!err) chk("first_write_t", first_w, 1);
    exp_q.delete();

    if (!err) begin
      if (op == 2'b10) mdl_clear();
      else if (op == 2'b00) begin
        if (!mdl_valid[idx]) mdl_count++;
        mdl_valid[idx] = 1'b1;
      end else begin
        if (mdl_valid[idx]) mdl_count--;
        mdl_valid[idx] = 1'b0;
      end
    end

    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("ready_after", cmd_ready, 1);
    chk("route_count", route_count, mdl_count);
    chk("entry_valid", entry_valid, mdl_bitmap());
  endtask

  initial begin
    int r, idx, pfx, guard;
    bit found;
    logic [1:0] op;
    logic [FW-1:0] ifc;
    n_checks = 0;
    n_errors = 0;
    mdl_clear();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_index = '0;
    cmd_net = '0;
    cmd_prefix = '0;
    cmd_if = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    run_init();

    send_cmd(2'b00, 3, 32'hC0A8_0000, 24, 4'h2);
    chk("add3_count", route_count, 1);
    chk("add3_bitmap", entry_valid, 32'h8);
    send_cmd(2'b00, 3, 32'h0A00_0A02, 8, 4'h1);
    send_cmd(2'b01, 3, 32'h0, 0, 4'h0);
    send_cmd(2'b01, 3, 32'h0, 0, 4'h0);

    send_cmd(2'b00, 32, 32'h0A00_0000, 24, 4'h2);
    send_cmd(2'b00, 4, 32'h0A00_0000, 33, 4'h2);
    send_cmd(2'b00, 5, 32'h0, 0, 4'h0);
    send_cmd(2'b11, 1, 32'h0, 8, 4'h3);

    send_cmd(2'b00, 0, 32'h0, 0, 4'h5);
    send_cmd(2'b00, 31, 32'hDEAD_BEEF, 32, 4'h7);
    chk("pre_clear_count", route_count, 2);
    send_cmd(2'b10, 0, 32'h0, 0, 4'h0);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r < 9) op = 2'b00;
      else if (r < 16) op = 2'b01;
      else if (r < 18) op = 2'b10;
      else op = 2'b11;
      idx = $urandom_range(0, 34);
      pfx = ($urandom_range(0, 15) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
      ifc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 12) == 0) begin
        pfx = 0;
        ifc = 4'h0;
      end
      send_cmd(op, idx, $urandom, pfx, ifc);
    end

    // Reset in the middle of a clear-all sweep.
    send_cmd(2'b00, 7, 32'h0102_0304, 16, 4'h9);
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 60) begin
      @(negedge clk);
      if (tcam_wr_en && tcam_wr_index == 8'd10) found = 1'b1;
      guard++;
    end
    chk("abort_reached", found, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("abort");
    mdl_clear();
    @(negedge clk);
    rst_n = 1'b1;
    run_init();
    send_cmd(2'b00, 9, 32'hAC10_FFFF, 12, 4'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
